// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: multi-cycle RISC-V "M" extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Iterative shift-add multiplier (MUL_STEP bits/cycle) and restoring radix-2 divider on
// operand magnitudes; the result sign is applied on the edge that enters DONE.
// Optional macro RV_MULDIV_FAST_MUL_EN: single-cycle signed multiply, MUL ops finish at accept.
module rv_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(XLEN / MUL_STEP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t r_state, w_next;

    logic [1:0]        r_op;
    logic [TAG_W-1:0]  r_tag;
    logic              r_neg_q, r_neg_r;
    logic [CNT_W-1:0]  r_cnt;
    logic [2*XLEN-1:0] r_acc;      // MUL: product accumulator; DIV: low half is the partial remainder
    logic [2*XLEN-1:0] r_opa;      // MUL: shifting multiplicand; DIV: low half is dividend/quotient
    logic [XLEN-1:0]   r_opb;      // MUL: shifting multiplier; DIV: divisor
    logic [XLEN-1:0]   r_rsp_data;
    logic [TAG_W-1:0]  r_rsp_tag;

    logic              w_accept, w_fast, w_last, w_b_zero, w_ovf;
    logic              w_a_signed, w_b_signed, w_sa, w_sb;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_fast_data;
    logic [2*XLEN-1:0] w_pp, w_mul_sum, w_mul_fin;
    logic [XLEN-1:0]   w_mul_res, w_div_res, w_rem_next, w_quo_next;
    logic [XLEN:0]     w_shift, w_sub;

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign rsp_data  = r_rsp_data;
    assign rsp_tag   = r_rsp_tag;

    // Request decode: signedness, magnitudes and special-case detection
    assign w_accept   = req_valid & req_ready & ~flush & ~rst;
    assign w_a_signed = (req_op == 3'd1) | (req_op == 3'd2) | (req_op == 3'd4) | (req_op == 3'd6);
    assign w_b_signed = (req_op == 3'd1) | (req_op == 3'd4) | (req_op == 3'd6);
    assign w_sa       = w_a_signed & req_a[XLEN-1];
    assign w_sb       = w_b_signed & req_b[XLEN-1];
    assign w_mag_a    = w_sa ? -req_a : req_a;
    assign w_mag_b    = w_sb ? -req_b : req_b;
    assign w_b_zero   = (req_b == '0);
    assign w_ovf      = ((req_op == 3'd4) | (req_op == 3'd6)) & (req_a == MIN_INT) & (req_b == '1);

`ifdef RV_MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]   w_fa, w_fb;
    logic [2*XLEN-1:0]      w_fprod;
    assign w_fa    = {w_a_signed & req_a[XLEN-1], req_a};
    assign w_fb    = {w_b_signed & req_b[XLEN-1], req_b};
    assign w_fprod = (2*XLEN)'(w_fa * w_fb);
    assign w_fast  = ~req_op[2] | w_b_zero | w_ovf;
`else
    assign w_fast  = req_op[2] & (w_b_zero | w_ovf);
`endif

    // Result for ops that complete on the accept edge
    always_comb begin
        w_fast_data = '1;
        if (req_op[2]) begin
            if (w_b_zero)
                w_fast_data = req_op[1] ? req_a : '1;
            else
                w_fast_data = req_op[1] ? '0 : MIN_INT;
        end
`ifdef RV_MULDIV_FAST_MUL_EN
        else begin
            w_fast_data = (req_op[1:0] == 2'd0) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
        end
`endif
    end

    // Iteration datapaths
    assign w_last     = ((r_state == S_MUL) && (r_cnt == MUL_LAST)) ||
                        ((r_state == S_DIV) && (r_cnt == DIV_LAST));
    assign w_pp       = r_opa * {{(2*XLEN-MUL_STEP){1'b0}}, r_opb[MUL_STEP-1:0]};
    assign w_mul_sum  = r_acc + w_pp;
    assign w_mul_fin  = r_neg_q ? -w_mul_sum : w_mul_sum;
    assign w_mul_res  = (r_op == 2'd0) ? w_mul_fin[XLEN-1:0] : w_mul_fin[2*XLEN-1:XLEN];
    assign w_shift    = {r_acc[XLEN-1:0], r_opa[XLEN-1]};
    assign w_sub      = w_shift - {1'b0, r_opb};
    assign w_rem_next = w_sub[XLEN] ? w_shift[XLEN-1:0] : w_sub[XLEN-1:0];
    assign w_quo_next = {r_opa[XLEN-2:0], ~w_sub[XLEN]};
    assign w_div_res  = r_op[1] ? (r_neg_r ? -w_rem_next : w_rem_next)
                                : (r_neg_q ? -w_quo_next : w_quo_next);

    // Next-state logic; flush overrides every transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_fast ? S_DONE : (req_op[2] ? S_DIV : S_MUL);
            S_MUL:  if (w_last) w_next = S_DONE;
            S_DIV:  if (w_last) w_next = S_DONE;
            S_DONE: if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Working registers: load on accept, then one multiply or divide step per cycle
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= req_op[1:0];
            r_tag   <= req_tag;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opa   <= {{XLEN{1'b0}}, w_mag_a};
            r_opb   <= w_mag_b;
        end else if (r_state == S_MUL) begin
            r_acc <= w_mul_sum;
            r_opa <= r_opa << MUL_STEP;
            r_opb <= r_opb >> MUL_STEP;
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (r_state == S_DIV) begin
            r_acc[XLEN-1:0] <= w_rem_next;
            r_opa[XLEN-1:0] <= w_quo_next;
            r_cnt           <= r_cnt + CNT_W'(1);
        end
    end

    // Response registers: written when entering DONE, held until the next result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data <= '0;
            r_rsp_tag  <= '0;
        end else if (w_accept && w_fast) begin
            r_rsp_data <= w_fast_data;
            r_rsp_tag  <= req_tag;
        end else if (w_last && !flush) begin
            r_rsp_data <= (r_state == S_MUL) ? w_mul_res : w_div_res;
            r_rsp_tag  <= r_tag;
        end
    end
endmodule
